bsg_cache_dma_responder: RTL and testbench

Memory-side endpoint of the bsg_cache DMA interface. Accepts DMA packets from a cache or a cache-side DMA shim such as the prefetcher. For a read packet it streams one block of read data back; for a write packet it sinks one block of write data. Each burst maps onto a synchronous 1RW memory port, so any cache or prefetcher can be closed against a local SRAM in simulation or in small SoC tiles.

---
 rtl/bsg_cache_dma_responder.sv | 128 ++++++++++++
 tb/tb_bsg_cache_dma_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_cache_dma_responder.sv
// Memory-side DMA endpoint: turns bsg_cache DMA read/write bursts into accesses
// on a synchronous 1RW memory port, with a 2-entry flow-through read return buffer.
module bsg_cache_dma_responder #(
  parameter int addr_width_p          = 32,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int mem_els_p             = 1024,
  localparam int dma_pkt_width_lp     = 1 + addr_width_p,
  localparam int mem_addr_width_lp    = (mem_els_p > 1) ? $clog2(mem_els_p) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,

  input  logic [dma_pkt_width_lp-1:0]  dma_pkt_i,
  input  logic                         dma_pkt_v_i,
  output logic                         dma_pkt_yumi_o,

  output logic [data_width_p-1:0]      dma_data_o,
  output logic                         dma_data_v_o,
  input  logic                         dma_data_ready_i,

  input  logic [data_width_p-1:0]      dma_data_i,
  input  logic                         dma_data_v_i,
  output logic                         dma_data_yumi_o,

  output logic                         mem_v_o,
  output logic                         mem_w_o,
  output logic [mem_addr_width_lp-1:0] mem_addr_o,
  output logic [data_width_p-1:0]      mem_data_o,
  input  logic [data_width_p-1:0]      mem_data_i
);

  localparam int lg_block_lp  = $clog2(block_size_in_words_p);
  localparam int lg_bytes_lp  = $clog2(data_width_p/8);
  localparam int cnt_width_lp = lg_block_lp + 1;
  localparam logic [cnt_width_lp-1:0] burst_lp = cnt_width_lp'(block_size_in_words_p);
  localparam logic [cnt_width_lp-1:0] last_lp  = cnt_width_lp'(block_size_in_words_p - 1);
  localparam logic [mem_addr_width_lp-1:0] blk_mask_lp =
    ~mem_addr_width_lp'(block_size_in_words_p - 1);

  typedef struct packed {
    logic                    write_not_read;
    logic [addr_width_p-1:0] addr;
  } dma_pkt_s;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  dma_pkt_s pkt;
  state_e   state;

  logic [addr_width_p-1:0]      word_addr;
  logic [mem_addr_width_lp-1:0] pkt_base, base;
  logic [cnt_width_lp-1:0]      issue_cnt, ret_cnt;

  // rd_inflight marks a read issued last cycle whose data is on mem_data_i now
  logic                         rd_inflight;
  logic [1:0][data_width_p-1:0] fifo_mem;
  logic                         fifo_rd_ptr, fifo_wr_ptr;
  logic [1:0]                   fifo_cnt;

  logic rd_issue, wr_fire, data_hs;

  assign pkt       = dma_pkt_i;
  assign word_addr = pkt.addr >> lg_bytes_lp;
  assign pkt_base  = mem_addr_width_lp'(word_addr) & blk_mask_lp;

  assign rd_issue = reset_n_i & (state == READ) & (issue_cnt < burst_lp)
                  & ((fifo_cnt + 2'(rd_inflight)) < 2'd2);
  assign wr_fire  = reset_n_i & (state == WRITE) & dma_data_v_i;

  assign dma_pkt_yumi_o  = reset_n_i & (state == IDLE) & dma_pkt_v_i;
  assign dma_data_yumi_o = wr_fire;

  // Empty buffer passes the returning word straight through to the head.
  assign dma_data_v_o = reset_n_i & (state == READ) & ((fifo_cnt != 2'd0) | rd_inflight);
  assign dma_data_o   = (fifo_cnt != 2'd0) ? fifo_mem[fifo_rd_ptr] : mem_data_i;
  assign data_hs      = dma_data_v_o & dma_data_ready_i;

  assign mem_v_o    = rd_issue | wr_fire;
  assign mem_w_o    = wr_fire;
  assign mem_addr_o = base + mem_addr_width_lp'(issue_cnt);
  assign mem_data_o = dma_data_i;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state       <= IDLE;
      base        <= '0;
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      rd_inflight <= 1'b0;
      fifo_cnt    <= 2'd0;
      fifo_rd_ptr <= 1'b0;
      fifo_wr_ptr <= 1'b0;
    end else begin
      rd_inflight <= rd_issue;
      // Every returning word is enqueued; a same-cycle pop of the bypassed word
      // advances the read pointer past it so the buffer stays consistent.
      if (rd_inflight) begin
        fifo_mem[fifo_wr_ptr] <= mem_data_i;
        fifo_wr_ptr           <= ~fifo_wr_ptr;
      end
      if (data_hs) fifo_rd_ptr <= ~fifo_rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(rd_inflight) - 2'(data_hs);

      case (state)
        IDLE: if (dma_pkt_v_i) begin
          base      <= pkt_base;
          issue_cnt <= '0;
          ret_cnt   <= '0;
          state     <= pkt.write_not_read ? WRITE : READ;
        end
        READ: begin
          if (rd_issue) issue_cnt <= issue_cnt + cnt_width_lp'(1);
          if (data_hs) begin
            ret_cnt <= ret_cnt + cnt_width_lp'(1);
            if (ret_cnt == last_lp) state <= IDLE;
          end
        end
        WRITE: if (wr_fire) begin
          issue_cnt <= issue_cnt + cnt_width_lp'(1);
          if (issue_cnt == last_lp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_cache_dma_responder.sv
// Scoreboard bench for bsg_cache_dma_responder against a behavioral 1RW SRAM.
module tb_bsg_cache_dma_responder;
  localparam int AW = 32, DW = 32, BLK = 8, ELS = 1024, MAW = 10;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic           reset_n_i;
  logic [AW:0]    dma_pkt_i;
  logic           dma_pkt_v_i, dma_pkt_yumi_o;
  logic [DW-1:0]  dma_data_o;
  logic           dma_data_v_o, dma_data_ready_i;
  logic [DW-1:0]  dma_data_i;
  logic           dma_data_v_i, dma_data_yumi_o;
  logic           mem_v_o, mem_w_o;
  logic [MAW-1:0] mem_addr_o;
  logic [DW-1:0]  mem_data_o, mem_data_i;

  bsg_cache_dma_responder #(
    .addr_width_p(AW), .data_width_p(DW),
    .block_size_in_words_p(BLK), .mem_els_p(ELS)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_ready_i(dma_data_ready_i),
    .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
  );

  // synchronous 1RW memory, read data valid the cycle after access
  logic [DW-1:0] sram [ELS];
  logic [DW-1:0] mem_q;
  always @(posedge clk_i)
    if (mem_v_o) begin
      if (mem_w_o) sram[mem_addr_o] <= mem_data_o;
      else         mem_q <= sram[mem_addr_o];
    end
  assign mem_data_i = mem_q;

  int n_chk = 0, n_fail = 0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0]     rq[$];
  logic [MAW+DW-1:0] wq[$];
  int cyc = 0, outst = 0, max_outst = 0, n_rd_hs = 0, n_wr_yumi = 0, last_hs_cyc = 0;
  bit stall_prev = 0;
  logic [DW-1:0] prev_d;

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (!reset_n_i) begin
      outst = 0;
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("rd_hold_v", dma_data_v_o, 1);
        chk("rd_hold_d", dma_data_o, prev_d);
      end
      if (dma_data_v_o && dma_data_ready_i) begin
        n_rd_hs++;
        last_hs_cyc = cyc;
        if (rq.size() == 0) chk("rd_extra_word", rq.size(), 1);
        else chk("rd_data", dma_data_o, rq.pop_front());
      end
      if (mem_v_o && !mem_w_o) outst++;
      if (dma_data_v_o && dma_data_ready_i) outst--;
      if (outst > max_outst) max_outst = outst;
      if (mem_v_o && mem_w_o) begin
        if (wq.size() == 0) chk("wr_extra", wq.size(), 1);
        else chk("wr_addr_data", {mem_addr_o, mem_data_o}, wq.pop_front());
      end
      if (dma_data_yumi_o) n_wr_yumi++;
      stall_prev = dma_data_v_o && !dma_data_ready_i;
      prev_d = dma_data_o;
    end
  end

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  function automatic logic [MAW-1:0] wbase(logic [AW-1:0] a);
    return MAW'(a >> 2) & 10'h3F8;
  endfunction

  int acc_cyc;
  task automatic accept(string tag);
    bit got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (dma_pkt_yumi_o) begin got = 1; acc_cyc = cyc; break; end
      step();
    end
    chk(tag, got, 1);
    step();
    dma_pkt_v_i = 0;
  endtask

  task automatic push_rd(logic [DW-1:0] d0);
    for (int i = 0; i < BLK; i++) rq.push_back(d0 + DW'(i));
  endtask

  task automatic do_write(logic [AW-1:0] a, logic [DW-1:0] d0, bit pend_rd);
    dma_pkt_i = {1'b1, a}; dma_pkt_v_i = 1;
    accept("wr_accept");
    n_wr_yumi = 0;
    if (pend_rd) begin
      push_rd(d0);
      dma_pkt_i = {1'b0, a}; dma_pkt_v_i = 1;
    end
    for (int i = 0; i < BLK; i++) begin
      dma_data_v_i = 1; dma_data_i = d0 + DW'(i);
      wq.push_back({wbase(a) + MAW'(i), d0 + DW'(i)});
      @(negedge clk_i);
      chk("wr_yumi", dma_data_yumi_o, 1);
      if (pend_rd) chk("busy_pkt_yumi", dma_pkt_yumi_o, 0);
      step();
    end
    dma_data_i = 32'hDEAD_BEEF; dma_data_v_i = 1;
    @(negedge clk_i);
    chk("idle_data_yumi", dma_data_yumi_o, 0);
    chk("idle_mem_v", mem_v_o, 0);
    if (pend_rd) chk("busy_pkt_accept", dma_pkt_yumi_o, 1);
    step();
    dma_data_v_i = 0; dma_pkt_v_i = 0;
    chk("wr_yumi_count", n_wr_yumi, BLK);
    chk("wr_q_empty", wq.size(), 0);
  endtask

  task automatic drain(bit bp);
    logic [15:0] pat = 16'b1110_0100_0001_1001; // lsb first: 1,0,0,1,1,0,0,0,0,0,1,...
    for (int k = 0; k < 300 && rq.size() != 0; k++) begin
      dma_data_ready_i = bp ? pat[k % 16] : 1'b1;
      step();
    end
    chk("rd_drain", rq.size(), 0);
    dma_data_ready_i = 1;
    chk("max_outst_le2", max_outst <= 2, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      chk("rd_idle_v", dma_data_v_o, 0);
      step();
    end
  endtask

  task automatic do_read(logic [AW-1:0] a, logic [DW-1:0] d0, bit bp);
    max_outst = 0;
    push_rd(d0);
    dma_pkt_i = {1'b0, a}; dma_pkt_v_i = 1; dma_data_ready_i = 1;
    accept("rd_accept");
    if (!bp) begin
      @(negedge clk_i);
      chk("rd_lat_t1_v", dma_data_v_o, 0);
      chk("rd_lat_t1_mem", mem_v_o, 1);
      step();
      @(negedge clk_i);
      chk("rd_lat_t2_v", dma_data_v_o, 1);
      step();
    end
    drain(bp);
    if (!bp) chk("rd_last_lat", last_hs_cyc - acc_cyc, BLK + 1);
  endtask

  task automatic chk_quiet(string tag);
    @(negedge clk_i);
    chk({tag, "_pkt_yumi"}, dma_pkt_yumi_o, 0);
    chk({tag, "_data_v"}, dma_data_v_o, 0);
    chk({tag, "_data_yumi"}, dma_data_yumi_o, 0);
    chk({tag, "_mem_v"}, mem_v_o, 0);
    step();
  endtask

  initial begin
    reset_n_i = 0; dma_pkt_i = '0; dma_pkt_v_i = 1; dma_data_i = 32'h5A5A_5A5A;
    dma_data_v_i = 1; dma_data_ready_i = 1;
    step();
    repeat (2) chk_quiet("reset");
    reset_n_i = 1; dma_pkt_v_i = 0;
    // stray write data while idle
    repeat (3) begin
      @(negedge clk_i);
      chk("stray_yumi", dma_data_yumi_o, 0);
      chk("stray_mem_v", mem_v_o, 0);
      step();
    end
    dma_data_v_i = 0;

    do_write(32'h0000_0040, 32'h11, 0);
    do_read (32'h0000_0044, 32'h11, 0);
    do_read (32'h0000_0044, 32'h11, 1);
    do_write(32'h0000_1FE0, 32'hA0, 0);
    do_read (32'h0001_1FE0, 32'hA0, 0);

    max_outst = 0;
    do_write(32'h0000_0080, 32'h30, 1);
    drain(0);

    // reset while the third word of a read is on the bus
    max_outst = 0; n_rd_hs = 0;
    push_rd(32'h11);
    dma_pkt_i = {1'b0, 32'h0000_0044}; dma_pkt_v_i = 1; dma_data_ready_i = 1;
    accept("rst_rd_accept");
    for (int k = 0; k < 20; k++) begin
      if (n_rd_hs >= 2) break;
      step();
    end
    chk("rst_reached", n_rd_hs, 2);
    reset_n_i = 0; dma_pkt_v_i = 1; dma_data_v_i = 1;
    repeat (2) chk_quiet("mid_reset");
    rq.delete();
    reset_n_i = 1; dma_pkt_v_i = 0; dma_data_v_i = 0;
    repeat (3) begin
      @(negedge clk_i);
      chk("post_rst_v", dma_data_v_o, 0);
      chk("post_rst_mem_v", mem_v_o, 0);
      step();
    end
    do_read(32'h0000_0044, 32'h11, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
